// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_pkg
// Purpose  : Shared types and constants for the iterative GCD engine.
// Revision : 1.0 - initial release
// ============================================================================
package gcd_pkg;

  // Default operand / result width in bits.
  localparam int unsigned XLEN_DEFAULT = 16;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // A load is accepted whenever the engine is not computing.
  function automatic logic load_accepted(input state_e state, input logic ld);
    return ld && (state != BUSY);
  endfunction

endpackage : gcd_pkg
`default_nettype wire

// File: rtl/gcd_datapath.sv
`default_nettype none
// ============================================================================
// Module   : gcd_datapath
// Purpose  : Operand registers, comparator, subtractor and swap mux for the
//            subtract/swap GCD algorithm. Sequenced by strobes from gcd_unit.
// Revision : 1.0 - initial release
// ============================================================================
import gcd_pkg::*;

module gcd_datapath #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            load_i,    // capture new operands
  input  logic            swap_i,    // exchange A and B
  input  logic            sub_i,     // A <- A - B
  input  logic            done_i,    // publish A as the result
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            b_zero_o,
  output logic            a_lt_b_o,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] diff;

  // Status back to the controller; both come straight from registers.
  assign b_zero_o = (b_q == '0);
  assign a_lt_b_o = (a_q < b_q);

  // The controller only requests a subtract when A >= B, so this never wraps.
  assign diff = a_q - b_q;

  // Next-state selection: load has priority, then done, then swap/subtract.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    if (load_i) begin
      a_d = a_i;
      b_d = b_i;
    end else if (done_i) begin
      result_d = a_q;
    end else if (swap_i) begin
      a_d = b_q;
      b_d = a_q;
    end else if (sub_i) begin
      a_d = diff;
    end
  end

  // Register update; reset clears operands and the published result.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule : gcd_datapath
`default_nettype wire

// File: rtl/gcd_unit.sv
`default_nettype none
// ============================================================================
// Module   : gcd_unit
// Purpose  : Iterative GCD accelerator. Loads two unsigned operands with a
//            single-cycle strobe, runs one subtract/swap step per clock and
//            holds the result with a valid flag until the next load or reset.
// Revision : 1.0 - initial release
// ============================================================================
import gcd_pkg::*;

module gcd_unit #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            ld_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] gcd_o
);

  state_e state_q;
  logic   ready_q;
  logic   valid_q;

  logic   load_s;
  logic   swap_s;
  logic   sub_s;
  logic   done_s;
  logic   b_zero;
  logic   a_lt_b;

  // Datapath strobes: exactly one step per BUSY cycle, B==0 first, then swap,
  // otherwise subtract. Reset is handled inside the datapath with priority.
  always_comb begin
    load_s = load_accepted(state_q, ld_i);
    done_s = 1'b0;
    swap_s = 1'b0;
    sub_s  = 1'b0;
    if (state_q == BUSY) begin
      if (b_zero) begin
        done_s = 1'b1;
      end else if (a_lt_b) begin
        swap_s = 1'b1;
      end else begin
        sub_s  = 1'b1;
      end
    end
  end

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_i) begin
            state_q <= BUSY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        BUSY: begin
          // Loads arriving now are dropped; no queuing.
          if (b_zero) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (ld_i) begin
            state_q <= BUSY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  gcd_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (load_s),
    .swap_i   (swap_s),
    .sub_i    (sub_s),
    .done_i   (done_s),
    .a_i      (a_i),
    .b_i      (b_i),
    .b_zero_o (b_zero),
    .a_lt_b_o (a_lt_b),
    .result_o (gcd_o)
  );

  assign ready_o = ready_q;
  assign valid_o = valid_q;

endmodule : gcd_unit
`default_nettype wire

// File: tb/tb_gcd_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_unit
// Purpose  : Self-checking bench for gcd_unit against a Euclid reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_unit;

  localparam int XLEN = 16;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            ld    = 1'b0;
  logic [XLEN-1:0] a     = '0;
  logic [XLEN-1:0] b     = '0;
  wire             ready;
  wire             valid;
  wire  [XLEN-1:0] gcd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_unit #(.XLEN(XLEN)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .ld_i    (ld),
    .a_i     (a),
    .b_i     (b),
    .ready_o (ready),
    .valid_o (valid),
    .gcd_o   (gcd)
  );

  // Reference result: Euclid's remainder algorithm.
  function automatic logic [XLEN-1:0] ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[XLEN-1:0];
  endfunction

  // Reference latency: count subtract/swap steps, plus the final B==0 step.
  function automatic int ref_steps(input int unsigned x, input int unsigned y);
    int n = 1;
    int unsigned t;
    while (y != 0) begin
      if (x < y) begin t = x; x = y; y = t; end
      else x = x - y;
      n++;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; ld = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic load_op(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    a = x; b = y; ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  // Cycles from the load edge until valid_o; flags ready_o asserted while busy.
  task automatic wait_valid(input int bound, output int lat, output bit timeout, output bit ready_bad);
    lat = 0; ready_bad = 1'b0;
    if (!valid && ready) ready_bad = 1'b1;
    while (!valid && lat < bound) begin
      step();
      lat++;
      if (!valid && ready) ready_bad = 1'b1;
    end
    timeout = !valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; ld = 1'b0;
    repeat (2) step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (gcd !== '0) begin errors++; $display("FAIL reset_gcd got %0d want 0", gcd); end
    reset = 1'b0;
    step();
    checks++; if (ready !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL idle_flags got ready=%b valid=%b want 1/0", ready, valid); end
  endtask

  task automatic test_basic();
    int lat; bit to, rb;
    apply_reset();
    load_op(16'd48, 16'd18);
    wait_valid(20, lat, to, rb);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no valid want valid"); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
    checks++; if (rb) begin errors++; $display("FAIL basic_ready_busy got ready=1 in BUSY want 0"); end
    checks++; if (gcd !== 16'd6) begin errors++; $display("FAIL basic_gcd got %0d want 6", gcd); end
  endtask

  task automatic test_vectors();
    logic [XLEN-1:0] va [8] = '{16'd1701, 16'd22000, 16'd42000, 16'd17, 16'd40664, 16'd0, 16'd25, 16'd0};
    logic [XLEN-1:0] vb [8] = '{16'd199, 16'd19900, 16'd1990, 16'd289, 16'd57408, 16'd25, 16'd0, 16'd0};
    logic [XLEN-1:0] ve [8] = '{16'd1, 16'd100, 16'd10, 16'd17, 16'd2392, 16'd25, 16'd25, 16'd0};
    int lat; bit to, rb;
    for (int i = 0; i < 8; i++) begin
      apply_reset();
      load_op(va[i], vb[i]);
      wait_valid(100, lat, to, rb);
      checks++; if (to) begin errors++; $display("FAIL vec%0d_timeout (%0d,%0d) got no valid want valid", i, va[i], vb[i]); end
      checks++; if (gcd !== ve[i]) begin errors++; $display("FAIL vec%0d_gcd (%0d,%0d) got %0d want %0d", i, va[i], vb[i], gcd, ve[i]); end
      checks++; if (lat !== ref_steps(va[i], vb[i])) begin errors++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, ref_steps(va[i], vb[i])); end
      checks++; if (rb) begin errors++; $display("FAIL vec%0d_ready_busy got 1 want 0", i); end
    end
  endtask

  task automatic test_ld_in_busy();
    int lat; bit to, rb;
    apply_reset();
    load_op(16'd48, 16'd18);
    repeat (3) step();
    a = 16'd100; b = 16'd75; ld = 1'b1;
    step();
    ld = 1'b0;
    wait_valid(20, lat, to, rb);
    checks++; if (to) begin errors++; $display("FAIL busy_ld_timeout got no valid want valid"); end
    checks++; if (gcd !== 16'd6) begin errors++; $display("FAIL busy_ld_gcd got %0d want 6", gcd); end
    checks++; if (lat + 4 !== 9) begin errors++; $display("FAIL busy_ld_latency got %0d want 9", lat + 4); end
  endtask

  task automatic test_ld_in_done();
    int lat; bit to, rb;
    load_op(16'd100, 16'd75);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL done_ld_valid_drop got %b want 0", valid); end
    wait_valid(50, lat, to, rb);
    checks++; if (to || gcd !== 16'd25) begin errors++; $display("FAIL done_ld_gcd got %0d (timeout=%0b) want 25", gcd, to); end
    checks++; if (lat !== ref_steps(100, 75)) begin errors++; $display("FAIL done_ld_latency got %0d want %0d", lat, ref_steps(100, 75)); end
  endtask

  task automatic test_reset_mid();
    int lat; bit to, rb;
    load_op(16'd65535, 16'd1);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (ready !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL midreset_flags got ready=%b valid=%b want 1/0", ready, valid); end
    checks++; if (gcd !== '0) begin errors++; $display("FAIL midreset_gcd got %0d want 0", gcd); end
    load_op(16'd48, 16'd18);
    wait_valid(20, lat, to, rb);
    checks++; if (to || gcd !== 16'd6) begin errors++; $display("FAIL midreset_reload got %0d (timeout=%0b) want 6", gcd, to); end
  endtask

  task automatic test_reset_and_ld();
    reset = 1'b1; ld = 1'b1; a = 16'd7; b = 16'd21;
    step();
    reset = 1'b0; ld = 1'b0;
    checks++; if (ready !== 1'b1 || valid !== 1'b0 || gcd !== '0) begin
      errors++; $display("FAIL rst_ld_now got ready=%b valid=%b gcd=%0d want 1/0/0", ready, valid, gcd);
    end
    repeat (5) step();
    checks++; if (ready !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL rst_ld_idle got ready=%b valid=%b want 1/0", ready, valid);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [XLEN-1:0] x, y;
    int lat, exp_lat; bit to, rb;
    for (int i = 0; i < 25; i++) begin
      x = XLEN'($urandom_range(0, 255) * $urandom_range(1, 8));
      y = XLEN'($urandom_range(0, 255) * $urandom_range(1, 8));
      exp_lat = ref_steps(x, y);
      load_op(x, y);
      wait_valid(exp_lat + 5, lat, to, rb);
      checks++; if (to || gcd !== ref_gcd(x, y)) begin
        errors++; $display("FAIL rand%0d_gcd (%0d,%0d) got %0d (timeout=%0b) want %0d", i, x, y, gcd, to, ref_gcd(x, y));
      end
      checks++; if (lat !== exp_lat || rb) begin
        errors++; $display("FAIL rand%0d_latency (%0d,%0d) got %0d ready_busy=%0b want %0d", i, x, y, lat, rb, exp_lat);
      end
      if (($urandom_range(0, 3)) == 0) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ld_in_busy();
    test_ld_in_done();
    test_reset_mid();
    test_reset_and_ld();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gcd_unit
`default_nettype wire

// File: doc/gcd_unit.md
# gcd_unit

Iterative greatest-common-divisor engine for unsigned XLEN-bit operands. Operands are loaded with a single-cycle strobe, and the GCD is computed by repeated subtract/swap, one step per clock. The result is then presented with a valid flag until the next load or reset. It is a standalone arithmetic accelerator block driven by a simple load/ready/valid handshake.

## Interface
- XLEN, 16, operand and result width in bits
- clk_i  input  1  single clock; all state updates on its rising edge
- reset_i  input  1  synchronous, active-high reset
- ld_i  input  1  load strobe; accepted only when ready_o=1
- a_i  input  XLEN  operand A, unsigned, sampled on accepted load
- b_i  input  XLEN  operand B, unsigned, sampled on accepted load
- ready_o  output  1  block can accept a load
- valid_o  output  1  gcd_o holds a completed result
- gcd_o  output  XLEN  result; 0 until the first completion

## Operation
- Reset behaviour:
  - State goes to IDLE.
  - Internal registers A, B and the result are cleared.
  - Outputs: ready_o=1, valid_o=0, gcd_o=0.
- States:
  - IDLE: ready_o=1, valid_o=0. ld_i=1 latches A←a_i, B←b_i and moves to BUSY.
  - BUSY: ready_o=0, valid_o=0. Exactly one step per cycle, in priority order:
    - B==0: result←A, move to DONE.
    - else A<B: swap A and B.
    - else: A←A−B.
  - DONE: ready_o=1, valid_o=1, gcd_o=result, held stable. ld_i=1 latches new operands and moves to BUSY, so valid_o drops the next cycle. Otherwise DONE holds indefinitely.
- ld_i is ignored in BUSY. No queuing; operands presented then are lost.
- Arithmetic: unsigned, XLEN bits. The A<B guard means A−B never underflows, so no extra bits are needed.
- Zero operands:
  - gcd(x,0)=x
  - gcd(0,y)=y
  - gcd(0,0)=0
- reset_i has priority over ld_i and over any in-flight computation. A reset mid-BUSY aborts to IDLE with gcd_o=0.

## Timing
- Load accepted at rising edge k, when ld_i=1, ready_o=1 and reset_i=0. BUSY begins in cycle k+1.
- Latency equals the number of BUSY steps S, including the final B==0 step. valid_o rises after edge k+S.
- Latency is data-dependent and unbounded by design except by operand magnitude. Worst case for XLEN=16 is (65535,1): roughly 65537 cycles.
- Example: (48,18) runs 9 steps, so valid_o rises 9 cycles after the load edge.
- Outputs are driven from registered state only. There are no combinational paths from inputs to outputs.

## Structure
- Package gcd_pkg:
  - state enum {IDLE, BUSY, DONE}
  - default XLEN constant
- Sub-module gcd_datapath:
  - Holds the A/B/result registers, comparator, subtractor and swap mux.
  - Controlled by load/step/done strobes from the FSM in gcd_unit.
  - Reports b_zero and a_lt_b status back to the FSM.
- gcd_unit contains the FSM and handshake logic and instantiates gcd_datapath.

## Test plan
- Reset, then load (48,18): gcd_o=6, with valid_o rising exactly 9 cycles after the load edge. ready_o=0 throughout BUSY.
- Sequential loads, each preceded by reset, then wait on valid_o with at most 100 cycles each:
  - (1701,199) → 1
  - (22000,19900) → 100
  - (42000,1990) → 10
  - (17,289) → 17
  - (40664,57408) → 2392
- Zero operands:
  - (0,25) → 25
  - (25,0) → 25
  - (0,0) → 0, with valid_o 1 cycle after load
- Handshake edges:
  - ld_i pulsed mid-BUSY with (100,75): ignored; original result is unchanged.
  - ld_i in DONE with (100,75): valid_o drops the next cycle, then gcd_o=25.
- Reset mid-computation:
  - Load (65535,1) and assert reset_i after 10 cycles: next cycle ready_o=1, valid_o=0, gcd_o=0.
  - Then load (48,18): gcd_o=6.
- Reset and ld_i asserted in the same cycle: reset wins, the block stays IDLE and no load occurs.
